// File: rtl/accum_pkg.sv
// accum_pkg: shared definitions for the accumulation stage.
//   accum_state_e : group state (IDLE = no term accumulated, ACCUM = mid-group)
//   acc_max/acc_min : most positive / most negative value of an acc_w-bit signed word
//   cnt_width     : width of the term counter, $clog2(len) with a floor of 1
package accum_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } accum_state_e;

  // Returned as 64-bit values; callers slice down to their accumulator width.
  function automatic logic signed [63:0] acc_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/sat_add_step.sv
// sat_add_step: one combinational accumulation step.
//   acc           in  ACC_W  signed running sum
//   term          in  IN_W   signed term, sign-extended to ACC_W internally
//   sum           out ACC_W  acc + term (wrapped, or clamped when ACCUM_SAT_EN)
//   step_overflow out 1      operands share a sign and the raw sum's sign differs
// Build option: define ACCUM_SAT_EN to clamp to MAX/MIN on overflow.
module sat_add_step
  import accum_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [IN_W-1:0]  term,
  output logic signed [ACC_W-1:0] sum,
  output logic                    step_overflow
);

  logic signed [ACC_W-1:0] term_ext;
  logic signed [ACC_W-1:0] raw_sum;

  // Size cast of a signed operand sign-extends.
  assign term_ext = ACC_W'(term);
  assign raw_sum  = acc + term_ext;

  assign step_overflow = (acc[ACC_W-1] == term_ext[ACC_W-1]) &&
                         (raw_sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef ACCUM_SAT_EN
  localparam logic signed [63:0] MAX_64 = acc_max(ACC_W);
  localparam logic signed [63:0] MIN_64 = acc_min(ACC_W);
  localparam logic signed [ACC_W-1:0] MAX_V = MAX_64[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] MIN_V = MIN_64[ACC_W-1:0];

  // On overflow both operands share a sign, so acc's sign picks the rail.
  always_comb begin
    sum = raw_sum;
    if (step_overflow) begin
      sum = acc[ACC_W-1] ? MIN_V : MAX_V;
    end
  end
`else
  always_comb begin
    sum = raw_sum;
  end
`endif

endmodule

// File: rtl/accum_stage.sv
// accum_stage: accumulates LEN consecutive signed terms into one ACC_W-bit
// result with valid/ready handshakes on both sides and a held output register.
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_clear          abort the group in progress (output register untouched)
//   in_valid/in_ready/in_data    term input (IN_W signed)
//   out_valid/out_ready/out_data result output (ACC_W signed)
//   out_ovf          signed overflow seen on any step of the result's group
// Build option: ACCUM_SAT_EN selects clamping instead of wrapping per step.
module accum_stage
  import accum_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_ovf
);

  localparam int CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic [CNT_W-1:0]        cnt_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic                    ovf_reg;
  logic                    out_valid_reg;
  logic signed [ACC_W-1:0] out_data_reg;
  logic                    out_ovf_reg;

  accum_state_e            state;
  logic signed [ACC_W-1:0] acc_base;
  logic                    ovf_base;
  logic signed [ACC_W-1:0] acc_next;
  logic                    step_overflow;
  logic                    ovf_next;
  logic                    is_final;
  logic                    in_fire;
  logic                    out_fire;

  assign state    = (cnt_reg == '0) ? IDLE : ACCUM;
  // A fresh group always starts from zero, independent of leftover register state.
  assign acc_base = (state == IDLE) ? '0 : acc_reg;
  assign ovf_base = (state == IDLE) ? 1'b0 : ovf_reg;
  assign is_final = (cnt_reg == CNT_LAST);

  // Only the final term waits for the output register; earlier terms keep flowing.
  assign in_ready = !i_reset && !i_clear &&
                    !(is_final && out_valid_reg && !out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;

  sat_add_step #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_step (
    .acc           (acc_base),
    .term          (in_data),
    .sum           (acc_next),
    .step_overflow (step_overflow)
  );

  assign ovf_next = ovf_base | step_overflow;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_reg       <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
      if (i_clear) begin
        cnt_reg <= '0;
        acc_reg <= '0;
        ovf_reg <= 1'b0;
      end else if (in_fire) begin
        if (is_final) begin
          // Overrides the out_fire clear when a new result lands the same cycle.
          out_valid_reg <= 1'b1;
          out_data_reg  <= acc_next;
          out_ovf_reg   <= ovf_next;
          cnt_reg       <= '0;
          acc_reg       <= '0;
          ovf_reg       <= 1'b0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          acc_reg <= acc_next;
          ovf_reg <= ovf_next;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_accum_stage.sv
// tb_accum_stage: directed, table-driven check of accum_stage (defaults) plus
// a second instance with ACC_W=10 for the overflow/saturation case.
module tb_accum_stage;

  logic              clk;
  logic              i_reset;
  logic              i_clear;
  logic              in_valid;
  logic signed [8:0] in_data;
  logic              out_ready;

  logic               in_ready;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_ovf;

  logic               in_ready10;
  logic               out_valid10;
  logic signed [9:0]  out_data10;
  logic               out_ovf10;

  int n_cmp = 0;
  int n_err = 0;

  accum_stage #(.IN_W(9), .ACC_W(16), .LEN(4)) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_clear   (i_clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  accum_stage #(.IN_W(9), .ACC_W(10), .LEN(4)) dut10 (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_clear   (i_clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready10),
    .in_data   (in_data),
    .out_valid (out_valid10),
    .out_ready (out_ready),
    .out_data  (out_data10),
    .out_ovf   (out_ovf10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic signed [8:0] data;
    logic              ordy;
    logic              exp_rdy;    // in_ready before the edge
    logic              exp_valid;  // out_valid after the edge
    int                exp_data;   // checked only when exp_valid
    logic              exp_ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic drive(input logic v, input logic signed [8:0] d,
                       input logic ordy, input logic clr, input logic rst);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    i_clear   = clr;
    i_reset   = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 68,-2,10,-4 -> 72
    vecs[0]  = '{1'b1, 9'sd68, 1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[1]  = '{1'b1, -9'sd2, 1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[2]  = '{1'b1, 9'sd10, 1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[3]  = '{1'b1, -9'sd4, 1'b1, 1'b1, 1'b1, 72, 1'b0};
    // eight 1s back to back -> two results of 4, each for one cycle
    vecs[4]  = '{1'b1, 9'sd1,  1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[5]  = '{1'b1, 9'sd1,  1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[6]  = '{1'b1, 9'sd1,  1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[7]  = '{1'b1, 9'sd1,  1'b1, 1'b1, 1'b1, 4,  1'b0};
    vecs[8]  = '{1'b1, 9'sd1,  1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[9]  = '{1'b1, 9'sd1,  1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[10] = '{1'b1, 9'sd1,  1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[11] = '{1'b1, 9'sd1,  1'b1, 1'b1, 1'b1, 4,  1'b0};
    // backpressure: 5,6,7 accepted, 8 stalls until out_ready -> 26
    vecs[12] = '{1'b1, 9'sd5,  1'b0, 1'b1, 1'b1, 4,  1'b0};
    vecs[13] = '{1'b1, 9'sd6,  1'b0, 1'b1, 1'b1, 4,  1'b0};
    vecs[14] = '{1'b1, 9'sd7,  1'b0, 1'b1, 1'b1, 4,  1'b0};
    vecs[15] = '{1'b1, 9'sd8,  1'b0, 1'b0, 1'b1, 4,  1'b0};
    vecs[16] = '{1'b1, 9'sd8,  1'b1, 1'b1, 1'b1, 26, 1'b0};

    // Reset
    drive(1'b0, 9'sd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    drive(1'b0, 9'sd0, 1'b1, 1'b0, 1'b0);
    check("rel_in_ready", int'(in_ready), 1);

    // Table
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].ordy, 1'b0, 1'b0);
      check($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vecs[i].exp_rdy));
      tick();
      check($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_out_data", i), int'(out_data), vecs[i].exp_data);
        check($sformatf("v%0d_out_ovf", i), int'(out_ovf), int'(vecs[i].exp_ovf));
      end
    end
    drive(1'b0, 9'sd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("bp_drain_valid", int'(out_valid), 0);

    // Four terms of 255: fits in 16 bits, overflows 10 bits
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 9'sd255, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("w16_valid", int'(out_valid), 1);
    check("w16_data", int'(out_data), 1020);
    check("w16_ovf", int'(out_ovf), 0);
    check("w10_valid", int'(out_valid10), 1);
`ifdef ACCUM_SAT_EN
    check("w10_data", int'(out_data10), 511);
`else
    check("w10_data", int'(out_data10), -4);
`endif
    check("w10_ovf", int'(out_ovf10), 1);
    drive(1'b0, 9'sd0, 1'b1, 1'b0, 1'b0);
    tick();

    // Clear with a 4th term present: term dropped, then 1..4 -> 10
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 9'sd1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 9'sd9, 1'b1, 1'b1, 1'b0);
    check("clr_in_ready", int'(in_ready), 0);
    tick();
    check("clr_no_output", int'(out_valid), 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 9'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("clr_valid", int'(out_valid), 1);
    check("clr_data", int'(out_data), 10);
    check("clr_w10_data", int'(out_data10), 10);
    check("clr_w10_ovf", int'(out_ovf10), 0);
    drive(1'b0, 9'sd0, 1'b1, 1'b0, 1'b0);
    tick();

    // Pending result (4, with ovf clear) plus 2 accumulated terms, then reset
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 9'sd1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("pend_valid", int'(out_valid), 1);
    check("pend_data", int'(out_data), 4);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 9'sd50, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 9'sd0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_in_ready", int'(in_ready), 0);
    tick();
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_ovf", int'(out_ovf), 0);
    drive(1'b0, 9'sd0, 1'b1, 1'b0, 1'b0);
    check("mid_rel_in_ready", int'(in_ready), 1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 9'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("post_rst_valid", int'(out_valid), 1);
    check("post_rst_data", int'(out_data), 10);
    drive(1'b0, 9'sd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_rst_drain", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accum_stage.md
# accum_stage

Signed accumulation stage sitting directly downstream of the signed adder: it consumes the adder's sign-extended (A+1)-bit sums and accumulates a fixed number of consecutive terms into one wider partial sum, as in a dot-product/MAC reduction. Inputs and outputs use valid/ready handshakes, and a completed sum is held in an output register until the consumer takes it. Signed overflow is detected on every step and reported per result.

## Interface
- IN_W, 9, width of the signed input term; matches the adder's A+1 output.
- ACC_W, 16, width of the signed accumulator and output; must be ≥ IN_W.
- LEN, 4, number of terms per result; must be ≥ 1.
- i_clk  input  1  clock; all logic is on the rising edge.
- i_reset  input  1  reset, synchronous, active-high.
- i_clear  input  1  synchronous abort of the group in progress.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the stage can accept a term this cycle.
- in_data  input  IN_W  signed term.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  the consumer takes the result this cycle.
- out_data  output  ACC_W  signed accumulated result.
- out_ovf  output  1  signed overflow occurred while forming out_data.

## Operation
- States:
  - IDLE: cnt==0, acc==0.
  - ACCUM: 0<cnt<LEN.
- Accept: in_fire = in_valid && in_ready.
- Output handshake: out_fire = out_valid && out_ready.
- On each in_fire:
  - acc_next = acc + sext(in_data) to ACC_W bits.
  - ovf_next = ovf | step_overflow, where step_overflow means the operand signs are equal and the result sign differs.
- Term count:
  - A non-final term (cnt<LEN-1) increments cnt.
  - The final term (cnt==LEN-1) loads acc_next into out_data and ovf_next into out_ovf, sets out_valid, and returns acc, ovf and cnt to 0 (IDLE).
  - With LEN==1, every term is final.
- in_ready = !i_reset && !i_clear && !(cnt==LEN-1 && out_valid && !out_ready).
  - Only the final term of a group is blocked by a pending result. Non-final terms keep accumulating under backpressure.
- out_valid clears on out_fire, unless a new final term is accepted in the same cycle. In that case out_valid stays 1 and out_data/out_ovf update.
- i_clear returns acc, ovf and cnt to 0 and drops any term presented that cycle. It has priority over in_fire and does not touch out_valid/out_data/out_ovf.
- out_data and out_ovf are stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_ovf=0, acc=0, cnt=0, state IDLE. in_ready=0 while i_reset is high and 1 in the cycle after release.
- Latency: out_valid rises in the cycle after the final term's in_fire.
- Throughput: one term per cycle. There are no bubbles between groups when out_ready is held high.
- Reset mid-group or with a result pending discards everything. No out_fire is issued for a discarded result.
- in_valid may fall without a transfer. in_data is sampled only on in_fire.

## Configuration
- ACCUM_SAT_EN defined:
  - Each step clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow.
  - Further terms continue from the clamped value.
  - out_ovf is still reported.
- ACCUM_SAT_EN undefined: acc wraps modulo 2^ACC_W and out_ovf is sticky per group.
- Handshake and latency are identical in both builds.

## Structure
- Shared package accum_pkg holds:
  - the state enum (IDLE, ACCUM);
  - the MAX/MIN constant functions of ACC_W;
  - the cnt width constant, $clog2(LEN) with a minimum of 1.
- One sub-module, sat_add_step: combinational ACC_W-bit signed add of acc and the sign-extended term, producing sum and step_overflow, with the clamp selected by ACCUM_SAT_EN.
- The top-level module holds the counter, the accumulator register, the output register and the handshake logic.

## Test plan
- Defaults, out_ready=1; feed 68, -2, 10, -4 -> one cycle after the 4th term out_valid=1, out_data=72, out_ovf=0.
- out_ready=1, 8 consecutive terms all equal to 1 -> two results of 4, each valid for exactly one cycle, in_ready never drops.
- out_ready=0 with a result pending; feed 4 more terms -> the first 3 are accepted, in_ready=0 at the 4th, and the first result stays stable. Raise out_ready -> the 4th term is accepted in the same cycle and out_data updates to the second sum.
- ACC_W=10, four terms of 255:
  - without ACCUM_SAT_EN -> out_data=-4, out_ovf=1;
  - with ACCUM_SAT_EN -> out_data=511, out_ovf=1.
- Feed 3 terms, pulse i_clear together with a 4th valid term -> that term is dropped, no output. The next 4 terms (1, 2, 3, 4) -> out_data=10.
- Hold a pending result and 2 accumulated terms, assert i_reset for one cycle -> out_valid=0, out_data=0, out_ovf=0. The next group of 4 produces a sum without the stale terms.
